// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared types and helpers for the synchronous FIFO slice.
//   fifo_status_t : packed bundle of the FIFO status/error flags
//   clog2_depth   : ceiling log2, used to size pointers and the count
//   CNT_W         : count width for the default 128-entry configuration
package fifo_pkg;

  localparam int DEFAULT_DEPTH = 128;

  // Ceiling log2 usable in constant expressions (parameter sizing).
  function automatic int clog2_depth(input int depth);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < depth) w = i + 1;
    end
    return w;
  endfunction

  localparam int CNT_W = clog2_depth(DEFAULT_DEPTH) + 1;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic err_overflow;
    logic err_underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem
// Simple dual-port RAM, DATA_W x DEPTH, written so it maps onto block RAM.
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset of the read output register only
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write word
//   rd_en   : read strobe; loads rd_data from rd_addr
//   rd_addr : read address
//   rd_data : registered read word, holds when rd_en is low
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [clog2_depth(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          rd_en,
  input  logic [clog2_depth(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]             rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage array has no reset so synthesis can keep it in block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read output register. A read and write to the same address in one
  // cycle returns the old contents, which the FIFO relies on when full.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo
// Parametrised single-clock FIFO with registered flags, occupancy count,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
// Ports:
//   clk, rst       : clock and synchronous active-high reset
//   wr_en, wr_data : write request and word
//   rd_en          : read request
//   rd_data        : registered read word, valid when rd_valid is high
//   rd_valid       : rd_data holds a word popped on the previous edge
//   full, empty    : count == DEPTH / count == 0
//   almost_full    : count >= AF_LEVEL
//   almost_empty   : count <= AE_LEVEL
//   count          : current occupancy
//   err_overflow   : sticky, a write was dropped
//   err_underflow  : sticky, a read was rejected
//   err_clr        : clears both sticky error flags
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 128,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      rd_en,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      rd_valid,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      err_overflow,
  output logic                      err_underflow,
  input  logic                      err_clr
);

  localparam int PTR_W = clog2_depth(DEPTH);
  localparam int CW    = PTR_W + 1;

  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT    = CW'(AE_LEVEL);

  // Parameter sanity: pointers rely on natural power-of-2 wrap, and the
  // thresholds must not overlap.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "sync_fifo: DEPTH must be a power of 2 and at least 2");
  end
  if (AE_LEVEL >= AF_LEVEL) begin : g_bad_levels
    $fatal(1, "sync_fifo: AE_LEVEL must be below AF_LEVEL");
  end

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_next;
  fifo_status_t     stat;
  logic             wr_acc;
  logic             rd_acc;
  logic             rd_valid_q;

  // A write into a full FIFO is still accepted when a read frees a slot in
  // the same cycle. A read from an empty FIFO is never accepted, so there is
  // no write-to-read bypass.
  always_comb begin
    rd_acc   = rd_en & ~stat.empty;
    wr_acc   = wr_en & (~stat.full | rd_acc);
    cnt_next = cnt + {{(CW-1){1'b0}}, wr_acc} - {{(CW-1){1'b0}}, rd_acc};
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  // Pointers, occupancy and flags. Flags are computed from the next count
  // so they line up with count in the same cycle. Error set beats err_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      rd_valid_q <= 1'b0;
      stat       <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0,
                      almost_empty: 1'b1, err_overflow: 1'b0,
                      err_underflow: 1'b0};
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      cnt                <= cnt_next;
      rd_valid_q         <= rd_acc;
      stat.full          <= (cnt_next == DEPTH_CNT);
      stat.empty         <= (cnt_next == '0);
      stat.almost_full   <= (cnt_next >= AF_CNT);
      stat.almost_empty  <= (cnt_next <= AE_CNT);
      stat.err_overflow  <= (wr_en & ~wr_acc) | (stat.err_overflow & ~err_clr);
      stat.err_underflow <= (rd_en & ~rd_acc) | (stat.err_underflow & ~err_clr);
    end
  end

  assign rd_valid      = rd_valid_q;
  assign count         = cnt;
  assign full          = stat.full;
  assign empty         = stat.empty;
  assign almost_full   = stat.almost_full;
  assign almost_empty  = stat.almost_empty;
  assign err_overflow  = stat.err_overflow;
  assign err_underflow = stat.err_underflow;

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo
// Self-checking bench for sync_fifo. A queue scoreboard holds the words the
// FIFO should contain; every cycle all outputs are compared against it.
module tb_sync_fifo;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 128;
  localparam int AF     = DEPTH - 4;
  localparam int AE     = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [7:0]        count;
  logic              err_overflow;
  logic              err_underflow;
  logic              err_clr;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] mdl_q [$];
  logic [DATA_W-1:0] last_data;
  logic              exp_ovf;
  logic              exp_unf;

  sync_fifo #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .full          (full),
    .empty         (empty),
    .almost_full   (almost_full),
    .almost_empty  (almost_empty),
    .count         (count),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow),
    .err_clr       (err_clr)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h @%0t",
               tag, obs, exp, $time);
    end
  endtask

  // Compare every output against the scoreboard state.
  task automatic checkState(input logic exp_valid);
    int n;
    n = mdl_q.size();
    checkOutput("rd_valid",      32'(rd_valid),      32'(exp_valid));
    checkOutput("rd_data",       rd_data,            last_data);
    checkOutput("count",         32'(count),         32'(n));
    checkOutput("full",          32'(full),          32'(n == DEPTH));
    checkOutput("empty",         32'(empty),         32'(n == 0));
    checkOutput("almost_full",   32'(almost_full),   32'(n >= AF));
    checkOutput("almost_empty",  32'(almost_empty),  32'(n <= AE));
    checkOutput("err_overflow",  32'(err_overflow),  32'(exp_ovf));
    checkOutput("err_underflow", 32'(err_underflow), 32'(exp_unf));
  endtask

  // Drive one cycle of traffic, advance the scoreboard, then check.
  task automatic applyStimulus(input logic wr, input logic [31:0] data,
                               input logic rd, input logic clr);
    logic rd_a;
    logic wr_a;
    rst     = 1'b0;
    wr_en   = wr;
    wr_data = data;
    rd_en   = rd;
    err_clr = clr;
    rd_a = rd && (mdl_q.size() != 0);
    wr_a = wr && ((mdl_q.size() != DEPTH) || rd_a);
    @(posedge clk);
    #1;
    if (rd_a) last_data = mdl_q.pop_front();
    if (wr_a) mdl_q.push_back(data);
    exp_ovf = (wr && !wr_a) || (exp_ovf && !clr);
    exp_unf = (rd && !rd_a) || (exp_unf && !clr);
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    err_clr = 1'b0;
    checkState(rd_a);
  endtask

  // One-cycle reset, optionally with a write request held high.
  task automatic resetDut(input logic wr);
    rst     = 1'b1;
    wr_en   = wr;
    wr_data = 32'hBAD0_0000;
    rd_en   = 1'b0;
    err_clr = 1'b0;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    wr_en   = 1'b0;
    mdl_q.delete();
    last_data = '0;
    exp_ovf   = 1'b0;
    exp_unf   = 1'b0;
    checkState(1'b0);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; wr_data = '0;
    last_data = '0; exp_ovf = 1'b0; exp_unf = 1'b0;

    $display("[TB] reset");
    resetDut(1'b0);

    $display("[TB] fill to full, then overflow");
    for (int i = 1; i <= DEPTH; i++) applyStimulus(1'b1, 32'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);

    $display("[TB] drain to empty, then underflow");
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);

    $display("[TB] interleaved traffic across pointer wrap");
    for (int i = 0; i < 64; i++)  applyStimulus(1'b1, 32'h1000 + 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 136; i++) applyStimulus(1'b1, 32'h2000 + 32'(i), 1'b1, 1'b0);
    for (int i = 0; i < 64; i++)  applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++)
      applyStimulus(1'($urandom_range(0, 1)), $urandom(),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    while (mdl_q.size() != 0) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);

    $display("[TB] full with simultaneous read and write");
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 32'h3000 + 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)    applyStimulus(1'b1, 32'h4000 + 32'(i), 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    $display("[TB] empty with simultaneous read and write");
    applyStimulus(1'b1, 32'h5555_AAAA, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 50; i++) applyStimulus(1'b1, 32'h6000 + 32'(i), 1'b0, 1'b0);
    resetDut(1'b1);
    applyStimulus(1'b1, 32'hCAFE_F00D, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Parametrised single-clock FIFO; next-generation replacement for the lab FIFO.
- Fully synchronous, with registered full/empty flags, occupancy count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags.
- Sits between a producer and a consumer in the same clock domain and is instantiated wherever a buffered 32-bit stream is needed.

Parameters:
- DATA_W, 32, word width in bits.
- DEPTH, 128, number of entries; power of 2, at least 2.
- AF_LEVEL, DEPTH-4, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 4, almost_empty asserts when count <= AE_LEVEL.

Ports:
- clk  in  1  clock; everything is on the rising edge.
- rst  in  1  synchronous active-high reset.
- wr_en  in  1  write request.
- wr_data  in  DATA_W  write word.
- rd_en  in  1  read request.
- rd_data  out  DATA_W  read word; registered.
- rd_valid  out  1  rd_data holds a newly popped word this cycle.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  $clog2(DEPTH)+1  current occupancy.
- err_overflow  out  1  sticky: a write was dropped.
- err_underflow  out  1  sticky: a read was rejected.
- err_clr  in  1  clears both sticky error flags.

Behaviour:

Reset:
- Reset is synchronous and active-high. On rst=1 at a clock edge: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, rd_valid=0, rd_data=0, both error flags=0.
- Memory contents are not reset.
- rst dominates every other input. Reset mid-stream discards all stored data, and the next cycle behaves as a freshly reset FIFO.

Accept rules (evaluated on state before the edge):
- wr_acc = wr_en & (!full | rd_acc).
- rd_acc = rd_en & !empty.

Write path:
- On wr_acc, mem[wr_ptr] <= wr_data and wr_ptr increments.
- wr_ptr is $clog2(DEPTH) bits and wraps naturally from DEPTH-1 to 0.

Read path:
- On rd_acc, rd_data <= mem[rd_ptr], rd_ptr increments (wraps the same way), and rd_valid <= 1.
- Otherwise rd_valid <= 0 and rd_data holds its last value.
- Read latency is 1 cycle from rd_en to rd_valid/rd_data.

Count update:
- count <= count + wr_acc - rd_acc.
- Simultaneous accepted read and write leaves count unchanged.

Full with wr_en and rd_en both high:
- Both are accepted.
- count stays DEPTH and full stays 1.

Empty with wr_en and rd_en both high:
- The write is accepted; there is no write-to-read bypass.
- The read is rejected and err_underflow is set.
- Next cycle count=1 and empty=0.

Flags:
- full, empty, almost_full, almost_empty are registered and derived from the next-state count, so they are valid in the same cycle as count.

Error flags:
- err_overflow sets when wr_en & !wr_acc.
- err_underflow sets when rd_en & !rd_acc.
- Both are sticky until err_clr=1 or rst.
- If err_clr and a new error occur in the same cycle, the set wins.

State machine:
- There is no explicit FSM. State is wr_ptr, rd_ptr, count, and the error bits.
- An implementation with one-hot states EMPTY/PARTIAL/FULL is acceptable if the flags stay identical.

Illegal parameters:
- Elaboration fails via assertion if DEPTH is not a power of 2, or if AE_LEVEL >= AF_LEVEL.

Decomposition:
- Package fifo_pkg:
  - fifo_status_t packed struct {full, empty, almost_full, almost_empty, err_overflow, err_underflow}.
  - Function clog2_depth.
  - Localparam CNT_W.
- Sub-module fifo_mem: simple dual-port RAM, DATA_W x DEPTH.
  - One synchronous write port and one registered synchronous read port.
  - Keeps storage inferable as BRAM.
- Pointer, count, and flag logic stays in sync_fifo.

Test Plan:
- Reset, then write 0x00000001..0x00000080 (128 writes, DEPTH=128) -> full=1 after 128th edge, count=128, almost_full=1 from count 124; a 129th write with rd_en=0 sets err_overflow=1, count stays 128.
- From full, read 128 words -> rd_data sequence 0x1..0x80, each one cycle after rd_en, rd_valid high each cycle; empty=1 after last, almost_empty=1 from count 4.
- Empty FIFO, rd_en=1 -> rd_valid=0, err_underflow=1; err_clr=1 next cycle -> err_underflow=0.
- Write 200 and read 200 interleaved at count ~64 so pointers wrap past 127 -> data order preserved, no error flags set.
- Full FIFO with wr_en=rd_en=1 for 10 cycles -> count stays 128, full stays 1, oldest data read out, new data appended, no overflow. Empty FIFO with both high -> count=1, err_underflow=1.
- Load 50 words, then assert rst for one cycle while wr_en=1 -> count=0, empty=1, rd_valid=0, errors 0; a subsequent read of a new write returns the new word.
